// File: rtl/onewire_responder.sv
// Device side of the single-wire half-duplex link: receives a command frame,
// hands it to local logic, then turns the line around and sends the response.
module onewire_responder #(
    parameter int BIT_CYCLES  = 8,
    parameter int TURN_CYCLES = 16,
    parameter int RSP_TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    inout  wire        io,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic [7:0] rsp_data,
    output logic       rsp_ready,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int CMAX = (RSP_TIMEOUT > BIT_CYCLES) ? RSP_TIMEOUT : BIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TURN_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, RX_START, RX_DATA, RX_STOP, RX_DRAIN,
        WAIT_RSP, TURN, TX_START, TX_DATA, TX_STOP
    } state_t;

    state_t        state, state_n;
    logic [1:0]    sync;
    logic          io_s;
    logic [CW-1:0] cyc, cyc_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [7:0]    rx_sh, rx_sh_n, tx_sh, tx_sh_n, cmd_data_n;
    logic          oe, oe_n, tx_bit, tx_bit_n;
    logic          cmd_valid_n, frame_err_n, timeout_err_n;
    logic          bit_end;

    assign io        = oe ? tx_bit : 1'bz;
    assign io_s      = sync[1];
    assign bit_end   = (cyc == CW'(BIT_CYCLES - 1));
    assign rsp_ready = (state == WAIT_RSP);
    assign busy      = (state != IDLE);

    // Synchronizer resets to the idle (pulled-up) level so reset exit is quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], io};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cyc         <= '0;
            bit_cnt     <= '0;
            tcnt        <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            cmd_data    <= '0;
            oe          <= 1'b0;
            tx_bit      <= 1'b1;
            cmd_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cyc         <= cyc_n;
            bit_cnt     <= bit_n;
            tcnt        <= tcnt_n;
            rx_sh       <= rx_sh_n;
            tx_sh       <= tx_sh_n;
            cmd_data    <= cmd_data_n;
            oe          <= oe_n;
            tx_bit      <= tx_bit_n;
            cmd_valid   <= cmd_valid_n;
            frame_err   <= frame_err_n;
            timeout_err <= timeout_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        cyc_n         = cyc + CW'(1);
        bit_n         = bit_cnt;
        // Turnaround counter free-runs from the stop sample and saturates.
        tcnt_n        = (tcnt == TW'(TURN_CYCLES)) ? tcnt : tcnt + TW'(1);
        rx_sh_n       = rx_sh;
        tx_sh_n       = tx_sh;
        cmd_data_n    = cmd_data;
        oe_n          = oe;
        tx_bit_n      = tx_bit;
        cmd_valid_n   = 1'b0;
        frame_err_n   = 1'b0;
        timeout_err_n = 1'b0;

        case (state)
            IDLE: begin
                cyc_n = '0;
                if (!io_s) state_n = RX_START;
            end
            RX_START: begin
                if (cyc == CW'(BIT_CYCLES / 2 - 1)) begin
                    cyc_n   = '0;
                    bit_n   = '0;
                    state_n = io_s ? IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    rx_sh_n = {io_s, rx_sh[7:1]};
                    bit_n   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_end) begin
                    cyc_n  = '0;
                    tcnt_n = '0;
                    if (io_s) begin
                        cmd_data_n  = rx_sh;
                        cmd_valid_n = 1'b1;
                        state_n     = WAIT_RSP;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = RX_DRAIN;
                    end
                end
            end
            RX_DRAIN: begin
                if (io_s) state_n = IDLE;
            end
            WAIT_RSP: begin
                // Handshake takes priority over a coincident timeout.
                if (rsp_valid) begin
                    tx_sh_n = rsp_data;
                    state_n = TURN;
                end else if (cyc == CW'(RSP_TIMEOUT - 1)) begin
                    timeout_err_n = 1'b1;
                    state_n       = IDLE;
                end
            end
            TURN: begin
                if (tcnt >= TW'(TURN_CYCLES - 1)) begin
                    oe_n     = 1'b1;
                    tx_bit_n = 1'b0;
                    cyc_n    = '0;
                    state_n  = TX_START;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    cyc_n    = '0;
                    bit_n    = '0;
                    tx_bit_n = tx_sh[0];
                    tx_sh_n  = tx_sh >> 1;
                    state_n  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cyc_n = '0;
                    bit_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        tx_bit_n = 1'b1;
                        state_n  = TX_STOP;
                    end else begin
                        tx_bit_n = tx_sh[0];
                        tx_sh_n  = tx_sh >> 1;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    oe_n     = 1'b0;
                    tx_bit_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_onewire_responder.sv
// Host-side bench for onewire_responder: drives frames on the shared wire and
// checks received commands, error pulses and response waveforms.
module tb_onewire_responder;

    localparam int BIT = 8;
    localparam int TURN = 16;
    localparam int TO = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       host_oe = 1'b0;
    logic       host_bit = 1'b1;
    wire        io;
    logic       cmd_valid, rsp_ready, frame_err, timeout_err, busy;
    logic [7:0] cmd_data;
    logic       rsp_valid = 1'b0;
    logic [7:0] rsp_data = 8'h00;

    int tests = 0;
    int fails = 0;

    assign io = host_oe ? host_bit : 1'bz;
    pullup (io);

    always #5 clk = ~clk;

    onewire_responder #(.BIT_CYCLES(BIT), .TURN_CYCLES(TURN), .RSP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .io(io),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .frame_err(frame_err), .timeout_err(timeout_err), .busy(busy)
    );

    // Monitor / local-logic model: records pulses, answers commands, captures io.
    int         cyc = 0, n_cv = 0, n_fe = 0, n_to = 0, n_long = 0, n_multi = 0;
    int         cv_cyc = 0, to_cyc = 0;
    logic [7:0] cv_data = 8'h00;
    logic       p_cv = 1'b0, p_fe = 1'b0, p_to = 1'b0;
    logic       auto_rsp = 1'b0;
    logic [7:0] rsp_byte = 8'h00;
    logic       cap_en = 1'b0;
    logic       cap[$];

    always @(negedge clk) begin
        cyc++;
        if (cmd_valid) begin n_cv++; cv_cyc = cyc; cv_data = cmd_data; end
        if (frame_err) n_fe++;
        if (timeout_err) begin n_to++; to_cyc = cyc; end
        if ((cmd_valid && p_cv) || (frame_err && p_fe) || (timeout_err && p_to)) n_long++;
        if (int'(cmd_valid) + int'(frame_err) + int'(timeout_err) > 1) n_multi++;
        p_cv = cmd_valid; p_fe = frame_err; p_to = timeout_err;
        if (rsp_valid) rsp_valid = 1'b0;
        if (cmd_valid && auto_rsp) begin rsp_valid = 1'b1; rsp_data = rsp_byte; end
        if (cap_en) cap.push_back(io);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        host_oe = 1'b1;
        for (int i = 0; i < 10; i++) begin
            host_bit = f[i];
            repeat (BIT) @(negedge clk);
        end
        host_oe = 1'b0;
        host_bit = 1'b1;
    endtask

    task automatic capture(input int n);
        cap.delete();
        cap_en = 1'b1;
        repeat (n) @(negedge clk);
        cap_en = 1'b0;
    endtask

    // Reference waveform: start 0, data LSB first, stop 1, each BIT samples wide.
    task automatic check_frame(input logic [7:0] r);
        int idx, good;
        logic [9:0] f;
        logic room;
        f = {1'b1, r, 1'b0};
        idx = -1;
        for (int i = 0; i < cap.size(); i++)
            if (idx < 0 && cap[i] === 1'b0) idx = i;
        room = (idx >= 0) && (idx + 10 * BIT <= cap.size());
        chk("tx_frame_seen", room, 1'b1);
        if (room) begin
            for (int k = 0; k < 10; k++) begin
                good = 0;
                for (int j = 0; j < BIT; j++)
                    if (cap[idx + k * BIT + j] === f[k]) good++;
                chk($sformatf("tx_bit%0d_of_%02h", k, r), good, BIT);
            end
            good = 0;
            for (int i = idx + 10 * BIT; i < cap.size(); i++)
                if (cap[i] !== 1'b1) good++;
            chk("tx_released_after", good, 0);
        end
    endtask

    task automatic count_low(output int zeros);
        zeros = 0;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i] !== 1'b1) zeros++;
    endtask

    task automatic run_xact(input logic [7:0] c, input logic [7:0] r);
        int n0;
        n0 = n_cv;
        auto_rsp = 1'b1;
        rsp_byte = r;
        send_frame(c, 1'b1);
        capture(150);
        chk($sformatf("cmd_valid_count_%02h", c), n_cv - n0, 1);
        chk("cmd_data_at_valid", cv_data, c);
        check_frame(r);
        chk("busy_after_xact", busy, 1'b0);
        chk("io_idle_after_xact", io, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] r, c;
        int idx, n0, n1, zeros;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_data", cmd_data, 8'h00);
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_rsp_ready", rsp_ready, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_io", io, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic transaction
        run_xact(8'hA5, 8'h3C);

        // Bad stop bit
        n0 = n_cv; n1 = n_fe;
        send_frame(8'h5A, 1'b0);
        capture(60);
        chk("ferr_count", n_fe - n1, 1);
        chk("ferr_no_cmd_valid", n_cv - n0, 0);
        chk("ferr_cmd_data_kept", cmd_data, 8'hA5);
        count_low(zeros);
        chk("ferr_no_transmit", zeros, 0);
        chk("ferr_busy_drops", busy, 1'b0);

        // Response timeout
        auto_rsp = 1'b0;
        n0 = n_cv; n1 = n_to;
        send_frame(8'h11, 1'b1);
        capture(320);
        chk("to_cmd_valid", n_cv - n0, 1);
        chk("to_cmd_data", cmd_data, 8'h11);
        chk("to_count", n_to - n1, 1);
        chk("to_latency", to_cyc - cv_cyc, TO);
        count_low(zeros);
        chk("to_io_never_driven", zeros, 0);
        chk("to_busy", busy, 1'b0);

        // Short glitch on idle line
        n0 = n_cv; n1 = n_fe;
        host_oe = 1'b1; host_bit = 1'b0;
        repeat (2) @(negedge clk);
        host_oe = 1'b0; host_bit = 1'b1;
        repeat (BIT / 2 + 3) @(negedge clk);
        chk("glitch_busy", busy, 1'b0);
        repeat (20) @(negedge clk);
        chk("glitch_no_cmd", n_cv - n0, 0);
        chk("glitch_no_ferr", n_fe - n1, 0);

        // Reset during the 4th transmitted data bit (forced to 0 so release is visible)
        auto_rsp = 1'b1;
        r = 8'($urandom) & 8'hF7;
        c = 8'($urandom);
        rsp_byte = r;
        send_frame(c, 1'b1);
        idx = -1;
        for (int i = 0; i < 200 && idx < 0; i++) begin
            @(negedge clk);
            if (io === 1'b0) idx = i;
        end
        chk("mid_tx_start_seen", idx >= 0, 1'b1);
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        chk("mid_tx_bit3_low", io, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_io_released", io, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cmd_data", cmd_data, 8'h00);
        chk("mid_rst_rsp_ready", rsp_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        capture(40);
        count_low(zeros);
        chk("post_rst_no_partial", zeros, 0);
        run_xact(8'hFF, 8'($urandom));

        // Back-to-back commands
        run_xact(8'h01, 8'($urandom));
        run_xact(8'h80, 8'($urandom));

        // Randomized commands and responses
        for (int k = 0; k < 3; k++) run_xact(8'($urandom), 8'($urandom));

        chk("pulses_one_cycle", n_long, 0);
        chk("pulses_exclusive", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
